deserializer: RTL
=================

Name: deserializer

Overview:
- Downstream neighbour of the serializer: samples a serial bit stream, assembles 32-bit packet_t words and hands each word to the next stage over the shared bus interface.
- This block acts as requester (req/ack).
- One-word holding buffer decouples reception from the bus handshake, so bit capture continues while a handshake is pending.
- Sticky overflow flag records any completed word lost because the holding buffer was still occupied.

Parameters:
- WORD_BITS, 32, number of data bits per word; fixed to $bits(packet_t), elaborated for loop bounds only.
- CNT_W, 6, bit-counter width; must hold WORD_BITS+1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit, sampled when din_en=1.
- din_en  input  1  bit-valid strobe; 1 = din carries a bit this cycle.
- overflow  output  1  sticky; set when a completed word is dropped.
- busy  output  1  1 while the bit counter is nonzero (a word is partially received).
- output_bus  bus.requester  -  req (out), ack (in), data (out, packet_t).

Behaviour:
- Reset (rst=1 at clock edge), for every output:
  - bit counter = 0, shift register = 0, holding register = 0, buffer-full = 0.
  - output_bus.req = 0, output_bus.data = 0, overflow = 0, busy = 0.
- Reset mid-word discards the partial word. Reset mid-handshake drops req the next cycle and discards the buffered word.
- Bit capture (din_en=1):
  - shift_reg <= {din, shift_reg[31:1]}, so the first received bit ends at bit 0 (LSB of field0) and the last at bit 31 (MSB of field3).
  - din_en=0 holds the counter and shift register; gaps between bits are legal.
- Word complete: the edge on which the 32nd bit is sampled.
  - Counter wraps to 0 on that same edge.
  - The word is the shifted value including that bit.
- Transfer to the holding register:
  - If buffer-full=0, or ack=1 in the same cycle (buffer being freed), load the holding register on the completion edge, set buffer-full, assert req from the next cycle.
  - Latency: last bit sampled at edge N, req=1 and data valid from edge N.
  - If buffer-full=1 and ack=0, drop the word and set overflow=1; the holding register is unchanged.
- Output FSM, states OUT_IDLE and OUT_REQ:
  - OUT_IDLE: req=0. Go to OUT_REQ when the holding register is loaded.
  - OUT_REQ: req=1, data = holding register, stable while req=1.
    - On ack=1: buffer-full clears and the FSM goes to OUT_IDLE, unless a new word completes in the same cycle; then it stays in OUT_REQ with the new data.
  - ack seen in OUT_IDLE is ignored.
- overflow clears only on rst.
- busy = (bit counter != 0).

Optional Feature:
- Macro: DESER_PARITY_EN.
- Defined:
  - Each word is 33 bits: 32 data bits followed by one even-parity bit over the whole 33.
  - The parity bit is not shifted into data.
  - Added output parity_err (1 bit, sticky, cleared by rst) is set when parity fails; the failing word is discarded (never loaded, no req).
  - Counter terminal count = 33.
- Undefined: 32-bit words, no parity_err port, terminal count 32.

Decomposition:
- Package definitions (shared with the serializer):
  - packet_t: packed struct of bytes field3..field0.
  - bus interface with requester/acknowledger modports.
  - Localparam PACKET_BITS = $bits(packet_t).
  - Output-state enum type.
- Natural sub-module: deser_shift_counter (shift register + bit counter + word_done pulse). The handshake FSM and holding register stay in the top module.

Test Plan:
- Reset then shift 0xA5C3_0F81 LSB-first with continuous din_en and ack tied 0 → req=1 from the cycle after the 32nd bit; data=32'hA5C3_0F81; overflow=0.
- Same word with din_en toggling 1/0 every other cycle → identical data; req rises after 63 cycles of din_en activity; busy=1 throughout.
- Two back-to-back words 0x1111_1111, 0x2222_2222, ack held 0 → data stays 0x1111_1111; overflow=1 after the 64th bit.
- Ack pulsed in the exact cycle the second word completes → req stays 1; data changes to 0x2222_2222; overflow=0.
- Assert rst after 17 bits, then send 0xDEAD_BEEF → data=0xDEAD_BEEF (no residue); busy=0 the cycle after rst.
- DESER_PARITY_EN: word 0x0000_0001 with parity bit 0 → parity_err=1, no req. Same word with parity bit 1 → req=1, data=0x0000_0001.

Source files
------------

// File: rtl/deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : deserializer_pkg
// Purpose : Packet word layout, output-handshake state type and shared sizes
//           used by the serializer/deserializer pair.
// Revision: 1.0  initial release
// ============================================================================
package deserializer_pkg;

    typedef struct packed {
        logic [7:0] field3;
        logic [7:0] field2;
        logic [7:0] field1;
        logic [7:0] field0;
    } packet_t;

    localparam int PACKET_BITS = $bits(packet_t);

    typedef enum logic [0:0] {
        OUT_IDLE = 1'b0,
        OUT_REQ  = 1'b1
    } out_state_t;

endpackage : deserializer_pkg
`default_nettype wire

// File: rtl/bus.sv
`default_nettype none
// ============================================================================
// Module  : bus
// Purpose : req/ack word-transfer interface between neighbouring stages.
// Revision: 1.0  initial release
// ============================================================================
interface bus;
    import deserializer_pkg::*;

    logic    req;
    logic    ack;
    packet_t data;

    modport requester    (output req, input ack, output data);
    modport acknowledger (input req, output ack, input data);
endinterface : bus
`default_nettype wire

// File: rtl/deserializer_shift_counter.sv
`default_nettype none
// ============================================================================
// Module  : deser_shift_counter
// Purpose : LSB-first shift register, bit counter and word-complete strobe.
//           DESER_PARITY_EN adds a trailing even-parity bit to every word.
// Revision: 1.0  initial release
// ============================================================================
module deser_shift_counter #(
    parameter int WORD_BITS = 32,
    parameter int CNT_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_din,
    input  logic                 i_din_en,
    output logic [WORD_BITS-1:0] o_word,
    output logic                 o_word_done,
    output logic                 o_par_ok,
    output logic                 o_busy
);
`ifdef DESER_PARITY_EN
    localparam int c_TERM = WORD_BITS + 1;
`else
    localparam int c_TERM = WORD_BITS;
`endif
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(c_TERM - 1);

    logic [CNT_W-1:0]     r_cnt;
    logic [WORD_BITS-1:0] r_shift;
    logic                 w_last;
    logic [WORD_BITS-1:0] w_shift_nxt;

    assign w_last      = (r_cnt == c_LAST);
    assign w_shift_nxt = {i_din, r_shift[WORD_BITS-1:1]};
    assign o_word_done = i_din_en && w_last;
    assign o_busy      = (r_cnt != '0);

`ifdef DESER_PARITY_EN
    logic r_par;

    // The terminal bit is parity only; the data word completed one bit earlier.
    assign o_word   = r_shift;
    assign o_par_ok = ~(r_par ^ i_din);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (i_din_en) begin
            r_par <= w_last ? 1'b0 : (r_par ^ i_din);
        end
    end
`else
    assign o_word   = w_shift_nxt;
    assign o_par_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_din_en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
`ifdef DESER_PARITY_EN
            if (!w_last) begin
                r_shift <= w_shift_nxt;
            end
`else
            r_shift <= w_shift_nxt;
`endif
        end
    end

endmodule : deser_shift_counter
`default_nettype wire

// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
// Module  : deserializer
// Purpose : Serial-to-packet converter with a one-word holding buffer and a
//           req/ack output stage. Optional feature macro: DESER_PARITY_EN.
// Revision: 1.0  initial release
// ============================================================================
module deserializer
    import deserializer_pkg::*;
#(
    parameter int WORD_BITS = PACKET_BITS,
    parameter int CNT_W     = 6
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  din,
    input  logic  din_en,
    output logic  overflow,
`ifdef DESER_PARITY_EN
    output logic  parity_err,
`endif
    output logic  busy,
    bus.requester output_bus
);
    logic [WORD_BITS-1:0] w_word;
    logic                 w_word_done;
    logic                 w_par_ok;
    logic                 w_word_ok;
    logic                 w_free;

    out_state_t r_state;
    packet_t    r_hold;
    logic       r_overflow;

    deser_shift_counter #(
        .WORD_BITS (WORD_BITS),
        .CNT_W     (CNT_W)
    ) u_shift (
        .clk         (clk),
        .rst         (rst),
        .i_din       (din),
        .i_din_en    (din_en),
        .o_word      (w_word),
        .o_word_done (w_word_done),
        .o_par_ok    (w_par_ok),
        .o_busy      (busy)
    );

    assign w_word_ok = w_word_done && w_par_ok;
    // The buffer counts as free when empty or when it is handed off this cycle.
    assign w_free    = (r_state == OUT_IDLE) || output_bus.ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= OUT_IDLE;
            r_hold     <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                OUT_IDLE: begin
                    if (w_word_ok) begin
                        r_hold  <= w_word;
                        r_state <= OUT_REQ;
                    end
                end
                OUT_REQ: begin
                    if (output_bus.ack) begin
                        if (w_word_ok) begin
                            r_hold <= w_word;
                        end else begin
                            r_state <= OUT_IDLE;
                        end
                    end
                end
                default: r_state <= OUT_IDLE;
            endcase
            if (w_word_ok && !w_free) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef DESER_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else if (w_word_done && !w_par_ok) begin
            r_parity_err <= 1'b1;
        end
    end

    assign parity_err = r_parity_err;
`endif

    assign output_bus.req  = (r_state == OUT_REQ);
    assign output_bus.data = r_hold;
    assign overflow        = r_overflow;

endmodule : deserializer
`default_nettype wire
